// File: rtl/nlfsr_search_ctrl.sv
// rtl/nlfsr_search_ctrl.sv - PRNG-driven NLFSR tap search with on-chip period measurement
// Each candidate is measured by stepping the NLFSR from 1 until it returns to 1 or the count saturates.
module nlfsr_search_ctrl #(
  parameter int          NUM_OF_TAPS = 6,
  parameter int          SIZE        = 16,
  parameter logic [31:0] SEED        = 32'd13413515,
  parameter int          MAX_TRIES   = 0,
  parameter bit          CONTINUOUS  = 1'b1
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic                     start,
  input  logic                     abort,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_OF_TAPS*8-1:0] out_taps,
  output logic                     started,
  output logic                     done,
  output logic                     exhausted,
  output logic [31:0]              tries
);

  localparam int IW = $clog2(SIZE);
  localparam int TW = (NUM_OF_TAPS > 1) ? $clog2(NUM_OF_TAPS) : 1;
  localparam logic [31:0]   SEED_EFF   = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [31:0]   PRNG_MASK  = 32'h8020_0003;
  localparam logic [31:0]   MAX_T      = 32'(MAX_TRIES);
  localparam logic [7:0]    TAP_MASK   = 8'(SIZE - 1);
  localparam logic [SIZE:0] FULL_COUNT = {1'b0, {SIZE{1'b1}}};
  localparam logic [SIZE:0] ONE_C      = (SIZE+1)'(1);
  localparam logic [SIZE-1:0] ONE_S    = SIZE'(1);
  localparam logic [TW-1:0] LAST_TAP   = TW'(NUM_OF_TAPS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_GEN    = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_REPORT = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]               state;
  logic [31:0]              prng;
  logic [31:0]              prng_next;
  logic [NUM_OF_TAPS*8-1:0] taps;
  logic [TW-1:0]            tap_idx;
  logic [SIZE-1:0]          nlfsr;
  logic [SIZE-1:0]          nlfsr_next;
  logic [SIZE:0]            count;
  logic [SIZE:0]            count_next;
  logic                     fb;
  logic                     eval_hit;
  logic                     eval_miss;
  logic [31:0]              tries_inc;
  logic                     limit_hit;
  logic                     report_stop;

  // Tap bytes are masked to SIZE-1, so only the low IW bits can ever be nonzero.
  always_comb begin
    prng_next = {1'b0, prng[31:1]} ^ (prng[0] ? PRNG_MASK : 32'd0);
    fb = nlfsr[SIZE-1] ^ (nlfsr[taps[IW-1:0]] & nlfsr[taps[8+IW-1:8]]);
    for (int i = 0; i < NUM_OF_TAPS; i++) begin
      fb = fb ^ nlfsr[taps[8*i +: IW]];
    end
    nlfsr_next  = {nlfsr[SIZE-2:0], fb};
    count_next  = count + ONE_C;
    eval_hit    = (nlfsr_next == ONE_S) && (count_next == FULL_COUNT);
    eval_miss   = !eval_hit && ((nlfsr_next == ONE_S) || (count_next == FULL_COUNT));
    tries_inc   = (tries == '1) ? tries : tries + 32'd1;
    limit_hit   = (MAX_TRIES != 0) && (tries_inc == MAX_T);
    report_stop = !CONTINUOUS || ((MAX_TRIES != 0) && (tries >= MAX_T));
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state     <= S_IDLE;
      prng      <= SEED_EFF;
      taps      <= '0;
      tap_idx   <= '0;
      nlfsr     <= '0;
      count     <= '0;
      tries     <= '0;
      out_taps  <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      exhausted <= 1'b0;
    end else if (abort) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      done      <= 1'b0;
      exhausted <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            tries   <= '0;
            tap_idx <= '0;
            state   <= S_GEN;
          end
        end
        S_GEN: begin
          prng <= prng_next;
          for (int i = 0; i < NUM_OF_TAPS; i++) begin
            if (tap_idx == TW'(i)) taps[8*i +: 8] <= prng_next[7:0] & TAP_MASK;
          end
          if (tap_idx == LAST_TAP) begin
            nlfsr <= ONE_S;
            count <= '0;
            state <= S_RUN;
          end else begin
            tap_idx <= tap_idx + TW'(1);
          end
        end
        S_RUN: begin
          nlfsr <= nlfsr_next;
          count <= count_next;
          if (eval_hit || eval_miss) tries <= tries_inc;
          if (eval_hit) begin
            out_taps  <= taps;
            out_valid <= 1'b1;
            state     <= S_REPORT;
          end else if (eval_miss) begin
            tap_idx <= '0;
            if (limit_hit) begin
              done      <= 1'b1;
              exhausted <= 1'b1;
              state     <= S_DONE;
            end else begin
              state <= S_GEN;
            end
          end
        end
        S_REPORT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            tap_idx   <= '0;
            if (report_stop) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              state <= S_GEN;
            end
          end
        end
        S_DONE: begin
          // PRNG is deliberately left alone so a restart explores new candidates.
          if (start) begin
            tries     <= '0;
            tap_idx   <= '0;
            done      <= 1'b0;
            exhausted <= 1'b0;
            state     <= S_GEN;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign started = (state != S_IDLE);

endmodule
